// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID pipeline register with a RUN/STALL/HALT sequencer.
// Define FETCH_STALL_COUNT_EN to build the saturating stall-cycle counter.
module fetch_ifid_stage #(
    parameter int unsigned          PC_W     = 16,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [PC_W-1:0]      RESET_PC = '0,
    parameter int unsigned          PC_INC   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_pause,
    input  logic               if_id_hold,
    input  logic               if_id_flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_plus,
    output logic               if_id_valid,
    output logic [1:0]         fetch_state,
    output logic [15:0]        stall_count
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StHalt  = 2'b10
    } fetch_state_e;

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_plus;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    id_pc_q;
    logic [PC_W-1:0]    id_pc_plus_q;
    logic               valid_q;
    logic               halted;

    assign halted    = (state_q == StHalt);
    assign pc_plus   = pc_q + PC_W'(PC_INC);
    assign imem_addr = pc_q;

    // A redirect overrides both pause and halt; otherwise the PC freezes in HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= branch_target;
        end else if (halted || pc_pause) begin
            pc_q <= pc_q;
        end else begin
            pc_q <= pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || branch_taken || if_id_flush) begin
            instr_q      <= '0;
            id_pc_q      <= '0;
            id_pc_plus_q <= '0;
            valid_q      <= 1'b0;
        end else if (if_id_hold) begin
            instr_q      <= instr_q;
            id_pc_q      <= id_pc_q;
            id_pc_plus_q <= id_pc_plus_q;
            valid_q      <= valid_q;
        end else if (halted) begin
            instr_q      <= '0;
            id_pc_q      <= '0;
            id_pc_plus_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            instr_q      <= imem_data;
            id_pc_q      <= pc_q;
            id_pc_plus_q <= pc_plus;
            valid_q      <= 1'b1;
        end
    end

    // A halt being squashed by a redirect or flush must not freeze fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun, StStall: begin
                    if (halt_req && !branch_taken && !if_id_flush) begin
                        state_q <= StHalt;
                    end else if (pc_pause && !branch_taken) begin
                        state_q <= StStall;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == StStall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

    assign if_id_instr   = instr_q;
    assign if_id_pc      = id_pc_q;
    assign if_id_pc_plus = id_pc_plus_q;
    assign if_id_valid   = valid_q;
    assign fetch_state   = state_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: cycle model compared every negedge plus literal checkpoints.
module tb_fetch_ifid_stage;

    logic        clk;
    logic        rst;
    logic        pc_pause;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus;
    logic        if_id_valid;
    logic [1:0]  fetch_state;
    logic [15:0] stall_count;

    int tests = 0;
    int fails = 0;

    fetch_ifid_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_pause      (pc_pause),
        .if_id_hold    (if_id_hold),
        .if_id_flush   (if_id_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus (if_id_pc_plus),
        .if_id_valid   (if_id_valid),
        .fetch_state   (fetch_state),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word at byte address a is A001 + a/2.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA001 + (a >> 1);
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = RUN, 1 = STALL, 2 = HALT.
    int m_pc, m_instr, m_ipc, m_iplus, m_valid, m_state, m_stall;
    bit m_live = 0;

    always @(posedge clk) begin
        int old_state;
        int old_pc;
        old_state = m_state;
        old_pc    = m_pc;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_ipc = 0; m_iplus = 0; m_valid = 0;
            m_state = 0; m_stall = 0; m_live = 1;
        end else begin
            if (branch_taken || if_id_flush || (!if_id_hold && old_state == 2)) begin
                m_instr = 0; m_ipc = 0; m_iplus = 0; m_valid = 0;
            end else if (!if_id_hold) begin
                m_instr = int'(mem_word(16'(old_pc)));
                m_ipc   = old_pc;
                m_iplus = (old_pc + 2) % 65536;
                m_valid = 1;
            end
            if (old_state == 1 && m_stall < 65535) m_stall = m_stall + 1;
            if (branch_taken) m_pc = int'(branch_target);
            else if (old_state == 2 || pc_pause) m_pc = old_pc;
            else m_pc = (old_pc + 2) % 65536;
            if (old_state == 2) m_state = 2;
            else if (halt_req && !branch_taken && !if_id_flush) m_state = 2;
            else if (pc_pause && !branch_taken) m_state = 1;
            else m_state = 0;
        end
    end

    always @(negedge clk) begin
        int exp_sc;
`ifdef FETCH_STALL_COUNT_EN
        exp_sc = m_stall;
`else
        exp_sc = 0;
`endif
        if (m_live) begin
            check("model_imem_addr", 32'(imem_addr), 32'(m_pc));
            check("model_instr", 32'(if_id_instr), 32'(m_instr));
            check("model_if_id_pc", 32'(if_id_pc), 32'(m_ipc));
            check("model_pc_plus", 32'(if_id_pc_plus), 32'(m_iplus));
            check("model_valid", 32'(if_id_valid), 32'(m_valid));
            check("model_state", 32'(fetch_state), 32'(m_state));
            check("model_stall_count", 32'(stall_count), 32'(exp_sc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sc;
        rst = 1; pc_pause = 0; if_id_hold = 0; if_id_flush = 0;
        branch_taken = 0; branch_target = 16'h0000; halt_req = 0;
        tick(); tick();
        check("reset_addr", 32'(imem_addr), 32'h0);
        check("reset_valid", 32'(if_id_valid), 32'h0);
        check("reset_state", 32'(fetch_state), 32'h0);
        check("reset_stall", 32'(stall_count), 32'h0);
        rst = 0;

        // Free run
        tick();
        check("run1_addr", 32'(imem_addr), 32'h2);
        check("run1_pc", 32'(if_id_pc), 32'h0);
        check("run1_instr", 32'(if_id_instr), 32'hA001);
        check("run1_valid", 32'(if_id_valid), 32'h1);
        tick();
        check("run2_pc", 32'(if_id_pc), 32'h2);
        check("run2_instr", 32'(if_id_instr), 32'hA002);
        tick();
        check("run3_addr", 32'(imem_addr), 32'h6);
        check("run3_pc", 32'(if_id_pc), 32'h4);
        check("run3_plus", 32'(if_id_pc_plus), 32'h6);

        // Stall for two cycles
        pc_pause = 1; if_id_hold = 1;
        tick();
        check("stall1_state", 32'(fetch_state), 32'h1);
        check("stall1_addr", 32'(imem_addr), 32'h6);
        check("stall1_pc", 32'(if_id_pc), 32'h4);
        tick();
        check("stall2_state", 32'(fetch_state), 32'h1);
        check("stall2_pc", 32'(if_id_pc), 32'h4);
        pc_pause = 0; if_id_hold = 0;
        tick();
`ifdef FETCH_STALL_COUNT_EN
        exp_sc = 2;
`else
        exp_sc = 0;
`endif
        check("unstall_state", 32'(fetch_state), 32'h0);
        check("unstall_count", 32'(stall_count), 32'(exp_sc));
        check("unstall_pc", 32'(if_id_pc), 32'h6);

        // Branch wins over pause and hold
        pc_pause = 1; if_id_hold = 1; branch_taken = 1; branch_target = 16'h0040;
        tick();
        check("br_addr", 32'(imem_addr), 32'h40);
        check("br_valid", 32'(if_id_valid), 32'h0);
        check("br_instr", 32'(if_id_instr), 32'h0);
        check("br_state", 32'(fetch_state), 32'h0);
        pc_pause = 0; if_id_hold = 0; branch_taken = 0;
        tick();
        check("br_next_pc", 32'(if_id_pc), 32'h40);
        check("br_next_instr", 32'(if_id_instr), 32'hA021);

        // Halt
        halt_req = 1;
        tick();
        halt_req = 0;
        check("halt_state", 32'(fetch_state), 32'h2);
        check("halt_addr", 32'(imem_addr), 32'h44);
        tick();
        check("halt_frozen", 32'(imem_addr), 32'h44);
        check("halt_bubble", 32'(if_id_valid), 32'h0);
        tick();
        check("halt_frozen2", 32'(imem_addr), 32'h44);
        branch_taken = 1; branch_target = 16'h0080;
        tick();
        branch_taken = 0;
        check("halt_br_addr", 32'(imem_addr), 32'h80);
        check("halt_br_state", 32'(fetch_state), 32'h2);
        tick();
        check("halt_br_hold", 32'(imem_addr), 32'h80);
        rst = 1;
        tick();
        rst = 0;
        check("halt_rst_addr", 32'(imem_addr), 32'h0);
        check("halt_rst_state", 32'(fetch_state), 32'h0);

        // Halt squashed by flush
        halt_req = 1; if_id_flush = 1;
        tick();
        halt_req = 0; if_id_flush = 0;
        check("hflush_state", 32'(fetch_state), 32'h0);
        check("hflush_addr", 32'(imem_addr), 32'h2);
        check("hflush_valid", 32'(if_id_valid), 32'h0);

        // Wrap at top of address space
        branch_taken = 1; branch_target = 16'hFFFE;
        tick();
        branch_taken = 0;
        check("wrap_pre_addr", 32'(imem_addr), 32'hFFFE);
        tick();
        check("wrap_addr", 32'(imem_addr), 32'h0);
        check("wrap_pc", 32'(if_id_pc), 32'hFFFE);
        check("wrap_plus", 32'(if_id_pc_plus), 32'h0);
        check("wrap_instr", 32'(if_id_instr), 32'h2000);

        // Pause without hold: duplicate fetch of the same PC
        pc_pause = 1;
        tick();
        check("dup1_addr", 32'(imem_addr), 32'h0);
        check("dup1_pc", 32'(if_id_pc), 32'h0);
        tick();
        check("dup2_pc", 32'(if_id_pc), 32'h0);
        check("dup2_valid", 32'(if_id_valid), 32'h1);
        pc_pause = 0;
        tick();
        check("dup_end_addr", 32'(imem_addr), 32'h2);

        // Halt requested while stalled
        pc_pause = 1;
        tick();
        halt_req = 1;
        tick();
        pc_pause = 0; halt_req = 0;
        check("stall_halt_state", 32'(fetch_state), 32'h2);
        tick(); tick();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
